// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    ST_CSUM  = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/imem_loader_packer.sv
// Byte counter and little-endian word assembly; flags the byte that completes a word.
module imem_loader_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              take,
  input  logic [BYTE_W-1:0] data,
  output logic              word_done_c,
  output logic [WORD_W-1:0] word_next_c,
  output logic [WORD_W-1:0] word
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  always_comb begin
    cnt_d       = cnt_q;
    word_d      = word_q;
    word_next_c = {data, word_q[WORD_W-1:BYTE_W]};
    word_done_c = take && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    if (take) begin
      cnt_d  = cnt_q + BCNT_W'(1);
      word_d = word_next_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it to instruction memory,
// then releases the core reset. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_FINAL = ST_CSUM;
`else
  localparam state_e ST_FINAL = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [WORD_W-1:0] len_q, len_d;
  logic [WORD_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  logic              fire_c;
  logic              take_c;
  logic              word_done_c;
  logic [WORD_W-1:0] word_next_c;

  assign fire_c = in_valid && in_ready_q;
  assign take_c = fire_c && ((state_q == ST_LEN) || (state_q == ST_DATA));

  imem_loader_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .take        (take_c),
    .data        (in_data),
    .word_done_c (word_done_c),
    .word_next_c (word_next_c),
    .word        (mem_wdata)
  );

  // Next state and datapath updates; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (take_c) csum_d = csum_q ^ in_data;
`endif
    case (state_q)
      ST_LEN: begin
        if (word_done_c) begin
          len_d = word_next_c;
          if (word_next_c > WORD_W'(MAX_WORDS)) state_d = ST_ERR;
          else if (word_next_c == '0)           state_d = ST_FINAL;
          else                                  state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_done_c) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d  = idx_q + WORD_W'(1);
        addr_d = addr_q + WORD_W'(BYTES_PER_WORD);
        if ((idx_q + WORD_W'(1)) < len_q) state_d = ST_DATA;
        else                              state_d = ST_FINAL;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (fire_c) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase

    in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_d == ST_CSUM) in_ready_d = 1'b1;
`endif
    mem_we_d   = (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    core_rst_d = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LEN;
      len_q      <= '0;
      idx_q      <= '0;
      addr_q     <= BASE_ADDR;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      core_rst_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = addr_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, first instruction-memory byte address written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 256, largest accepted program length in 32-bit words.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  byte-stream producer holds a valid byte.
REQ-006 The block SHALL have port in_data  input  8  stream byte.
REQ-007 The block SHALL have port in_ready  output  1  loader accepts the byte this cycle.
REQ-008 The block SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-009 The block SHALL have port mem_addr  output  32  instruction-memory byte address.
REQ-010 The block SHALL have port mem_wdata  output  32  instruction word to write.
REQ-011 The block SHALL have port core_rst  output  1  active-low reset to the processor core.
REQ-012 The block SHALL have port done  output  1  program fully loaded.
REQ-013 The block SHALL have port error  output  1  load aborted.

Function
REQ-014 A byte SHALL transfer only on a rising edge where in_valid and in_ready are both 1.
REQ-015 The stream format SHALL be: 4 length bytes (word count N, little-endian), 4*N payload bytes, then the optional checksum byte (REQ-029).
REQ-016 Payload words SHALL assemble little-endian: first byte -> mem_wdata[7:0], fourth byte -> [31:24].
REQ-017 States SHALL be LEN, DATA, WRITE, CSUM, DONE, ERR.
REQ-018 LEN SHALL hold in_ready=1 and, after the 4th byte, go to ERR if N>MAX_WORDS, to DONE (or CSUM when enabled) if N=0, else to DATA.
REQ-019 DATA SHALL hold in_ready=1 and go to WRITE on the edge accepting the 4th byte of a word.
REQ-020 WRITE SHALL last exactly one cycle with mem_we=1, in_ready=0, mem_addr=BASE_ADDR+4*k for word index k (0-based).
REQ-021 After WRITE the word index SHALL increment and the block SHALL go to DATA if k+1<N, else to DONE (or CSUM when enabled).
REQ-022 DONE SHALL be terminal: done=1, core_rst=1, in_ready=0, mem_we=0.
REQ-023 ERR SHALL be terminal: error=1, core_rst=0, in_ready=0, mem_we=0.
REQ-024 core_rst SHALL be 0 in every state except DONE.
REQ-025 Bytes presented while in_ready=0 SHALL be ignored and SHALL NOT alter state.
REQ-026 mem_addr arithmetic SHALL be 32-bit and wrap modulo 2^32.

Reset
REQ-027 rst=0 SHALL immediately, at any point including mid-word or during WRITE, force state LEN, clear byte and word counters, length, word buffer and checksum, and drive in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_rst=0, done=0, error=0.
REQ-028 in_ready SHALL first rise in the first cycle after rst deasserts.

Configuration
REQ-029 With IMEM_LOADER_CHECKSUM_EN defined, CSUM SHALL accept one byte (in_ready=1) and go to DONE if it equals the XOR of all prior stream bytes, length bytes included, else to ERR.
REQ-030 Without IMEM_LOADER_CHECKSUM_EN, the CSUM state and checksum register SHALL be absent and the last WRITE (or N=0) SHALL go directly to DONE.

Structure
REQ-031 Package imem_loader_pkg SHALL hold the state enumeration type and the byte-per-word constant (4).
REQ-032 Sub-module imem_loader_packer SHALL hold the byte counter and the 32-bit little-endian shift/assembly register, signalling word-complete to the FSM.

Verification
REQ-033 Length 00 00 00 00 -> done=1, core_rst=1, no mem_we pulse (checksum 00 when enabled).
REQ-034 N=2, bytes 13 00 00 00, B7 02 00 00 -> mem_we at addr BASE_ADDR with 0000_0013, then BASE_ADDR+4 with 0000_02B7, then done=1.
REQ-035 Length 01 01 00 00 (257) with MAX_WORDS=256 -> error=1, core_rst=0, no mem_we pulse.
REQ-036 in_valid toggled 1/0 every cycle during N=1 payload -> single correct write, no byte lost or duplicated.
REQ-037 rst pulsed low after 2 of 4 payload bytes, then full N=1 stream resent -> one write at BASE_ADDR with the resent word.
REQ-038 With IMEM_LOADER_CHECKSUM_EN: N=1, word 0000_0013, checksum byte 12 -> done=1; checksum 00 -> error=1.
